gf_cmul_stream: RTL and testbench
=================================

Name: gf_cmul_stream

Overview:
- Streaming, pipelined GF(2^8) constant multiplier for AES round datapaths.
- Multiplies every byte of an NBYTES-wide state by a coefficient selected per beat: forward MixColumns coefficients 01/02/03 or inverse MixColumns coefficients 09/0B/0D/0E.
- Provides valid/ready flow control, configurable pipeline depth, a mode echo and a completed-beat counter.
- Sits between ShiftRows/SubBytes outputs and the column XOR network in both cipher directions.

Parameters:
- NBYTES, 16, bytes per beat (1..32); data width is 8*NBYTES.
- STAGES, 2, register stages from input acceptance to output (1..4).
- CNT_W, 16, width of the completed-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_mode  in  3  coefficient select: 0=01, 1=02, 2=03, 3=09, 4=0B, 5=0D, 6=0E, 7=reserved.
- in_data  in  8*NBYTES  state in, ascending bit index [0:8*NBYTES-1]; byte k = bits [8k:8k+7]; lowest index of each byte is its MSB.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  8*NBYTES  products, same byte ordering as in_data.
- out_mode  out  3  in_mode value carried with the beat.
- out_err  out  1  beat was issued with in_mode=7.
- done_cnt  out  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (async assert, sync release) clears all stage valid bits, out_data, out_mode, out_err and done_cnt to 0. in_ready is 1 once rst is low.
- Handshakes:
  - Input accepted on a cycle where in_valid && in_ready.
  - Output completes on a cycle where out_valid && out_ready.
- Arithmetic:
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0x00), where b[7] is the byte MSB.
  - 02=xt(b); 03=xt(b)^b; 09=x8^b; 0B=x8^x2^b; 0D=x8^x4^b; 0E=x8^x4^x2, with x2=xt(b), x4=xt(x2), x8=xt(x4).
  - Mode 7 passes data unchanged (coefficient 01) and sets out_err for that beat only.
  - All NBYTES lanes are independent and use the same mode.
- Pipeline:
  - Product is computed combinationally from in_data/in_mode and captured into stage 1 on acceptance. Stages 2..STAGES are pure delay.
  - mode and err travel with the data in each stage.
- Flow control:
  - Global enable en = !out_valid || out_ready. in_ready = en.
  - When en=0, every stage holds its contents (data, mode, err, valid); no beat is dropped or duplicated.
  - When en=1, each stage shifts and stage 1 loads the accepted beat or a bubble.
  - Bubbles are not collapsed.
- Latency: a beat accepted in cycle t gives out_valid in cycle t+STAGES if no stall occurs. Each stall cycle adds exactly one cycle.
- Throughput: 1 beat/cycle with out_ready held high.
- out_data, out_mode and out_err must stay stable while out_valid && !out_ready.
- done_cnt increments by 1 on each output handshake. It wraps from 2^CNT_W-1 to 0 with no flag.
- Simultaneous accept and output handshake in one cycle is legal and required at full rate.
- Reset mid-stream: all in-flight beats are discarded immediately, out_valid drops asynchronously, done_cnt returns to 0.
- in_data/in_mode are ignored when in_valid=0; X on them must not propagate into stage valid bits.

Test Plan:
- NBYTES=16, STAGES=2. Send all bytes 0x57 with modes 3,4,5,6 back-to-back, out_ready=1 -> outputs all-D9, all-77, all-9E, all-67 starting 2 cycles after the first accept, on consecutive cycles; done_cnt=4.
- Send all bytes 0x80 with modes 1,2,3 -> all-1B, all-9B, all-EC (reduction path exercised).
- Byte k = k (0x00..0x0F), mode 0, then mode 7 -> first output equals the input with out_err=0; second equals the input with out_err=1, out_mode=7.
- Stream 8 beats with out_ready toggling 1,0,0,1,... -> no loss or duplication, order preserved, outputs stable during stalls, in_ready=0 exactly when out_valid && !out_ready; done_cnt=8.
- Pulse rst with 2 beats in flight -> out_valid=0 immediately, done_cnt=0, and the next accepted beat emerges after exactly STAGES cycles.
- CNT_W=4: complete 17 beats -> done_cnt=1. Repeat the first test for STAGES=1 and STAGES=4 -> latency 1 and 4 cycles respectively.

Source files
------------

// File: rtl/gf_cmul_stream.sv
// Streaming GF(2^8) constant multiplier for AES (Inv)MixColumns lanes.
// Every byte of a beat is scaled by one per-beat coefficient, then delayed through a stallable pipeline.
module gf_cmul_stream #(
    parameter int NBYTES = 16,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_mode,
    input  logic [0:8*NBYTES-1]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:8*NBYTES-1]   out_data,
    output logic [2:0]            out_mode,
    output logic                  out_err,
    output logic [CNT_W-1:0]      done_cnt
);

    localparam int W = 8 * NBYTES;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] cmul(input logic [7:0] b, input logic [2:0] mode);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        case (mode)
            3'd1:    return x2;
            3'd2:    return x2 ^ b;
            3'd3:    return x8 ^ b;
            3'd4:    return x8 ^ x2 ^ b;
            3'd5:    return x8 ^ x4 ^ b;
            3'd6:    return x8 ^ x4 ^ x2;
            default: return b;   // coefficient 01, also used for the reserved mode
        endcase
    endfunction

    logic [0:W-1]        product;
    logic [0:W-1]        stg_data [STAGES];
    logic [2:0]          stg_mode [STAGES];
    logic [STAGES-1:0]   stg_valid;
    logic [STAGES-1:0]   stg_err;
    logic                en;

    // Byte k occupies ascending bits [8k:8k+7], so the part-select lands MSB-first in an [7:0] byte.
    always_comb begin
        product = '0;
        for (int k = 0; k < NBYTES; k++) begin
            product[8*k +: 8] = cmul(in_data[8*k +: 8], in_mode);
        end
    end

    // One global enable: the whole pipe advances or freezes together, so bubbles are never collapsed.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // NOTE: every stage is reset, not just the valid bits, because out_data/out_mode/out_err
    // must read 0 in reset and the pipe is shallow enough that this costs little.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= '0;
            stg_err   <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stg_data[s] <= '0;
                stg_mode[s] <= '0;
            end
        end else if (en) begin
            // NOTE: non-blocking assignments make every stage read its predecessor's old value,
            // so the loop order below does not matter.
            stg_valid[0] <= in_valid;
            if (in_valid) begin
                stg_data[0] <= product;
                stg_mode[0] <= in_mode;
                stg_err[0]  <= (in_mode == 3'd7);
            end
            for (int s = 1; s < STAGES; s++) begin
                stg_valid[s] <= stg_valid[s-1];
                stg_data[s]  <= stg_data[s-1];
                stg_mode[s]  <= stg_mode[s-1];
                stg_err[s]   <= stg_err[s-1];
            end
        end
    end

    assign out_valid = stg_valid[STAGES-1];
    assign out_data  = stg_data[STAGES-1];
    assign out_mode  = stg_mode[STAGES-1];
    assign out_err   = stg_err[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gf_cmul_stream.sv
// Self-checking bench for gf_cmul_stream: three instances (STAGES 2/1/4) share the input stream;
// table-driven coefficient vectors plus hand-written stall, reset and counter-wrap sequences.
module tb_gf_cmul_stream;

    localparam int NB = 16;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [7:0] b;
        logic [2:0] m;
        logic [7:0] exp;
        logic       err;
    } vec_t;

    typedef struct {
        logic [0:W-1] d;
        logic [2:0]   m;
        logic         e;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic [2:0]    in_mode;
    logic [0:W-1]  in_data;
    logic          out_ready;
    logic          rdy_one;

    logic          ir_a, ov_a, oe_a;
    logic [0:W-1]  od_a;
    logic [2:0]    om_a;
    logic [15:0]   dc_a;
    logic          ir_b, ov_b, oe_b;
    logic [0:W-1]  od_b;
    logic [2:0]    om_b;
    logic [3:0]    dc_b;
    logic          ir_c, ov_c, oe_c;
    logic [0:W-1]  od_c;
    logic [2:0]    om_c;
    logic [3:0]    dc_c;

    gf_cmul_stream #(.NBYTES(NB), .STAGES(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
        .out_mode(om_a), .out_err(oe_a), .done_cnt(dc_a));

    gf_cmul_stream #(.NBYTES(NB), .STAGES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov_b), .out_ready(rdy_one), .out_data(od_b),
        .out_mode(om_b), .out_err(oe_b), .done_cnt(dc_b));

    gf_cmul_stream #(.NBYTES(NB), .STAGES(4), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_mode(in_mode),
        .in_data(in_data), .out_valid(ov_c), .out_ready(rdy_one), .out_data(od_c),
        .out_mode(om_c), .out_err(oe_c), .done_cnt(dc_c));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [0:W-1] fill(input logic [7:0] b);
        logic [0:W-1] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = b;
        return r;
    endfunction

    // Reference multiply: shift-and-add in GF(2^8), independent of the xtime decomposition.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = c;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [0:W-1] model(input logic [0:W-1] d, input logic [2:0] m);
        logic [0:W-1] r;
        logic [7:0]   coef;
        case (m)
            3'd1: coef = 8'h02;  3'd2: coef = 8'h03;  3'd3: coef = 8'h09;
            3'd4: coef = 8'h0b;  3'd5: coef = 8'h0d;  3'd6: coef = 8'h0e;
            default: coef = 8'h01;
        endcase
        for (int k = 0; k < NB; k++) r[8*k +: 8] = gmul(d[8*k +: 8], coef);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Expects beat idx of the table at this sample point, or no beat when idx is out of range.
    task automatic chk_out(input string tag, input int idx, input int n, input vec_t v,
                           input logic ov, input logic [0:W-1] od, input logic [2:0] om, input logic oe);
        if (idx >= 0 && idx < n) begin
            check({tag, "_valid"}, W'(ov), W'(1'b1));
            check({tag, "_data"},  W'(od), W'(fill(v.exp)));
            check({tag, "_mode"},  W'(om), W'(v.m));
            check({tag, "_err"},   W'(oe), W'(v.err));
        end else begin
            check({tag, "_idle"},  W'(ov), W'(1'b0));
        end
    endtask

    vec_t tbl [11];
    beat_t q [$];

    initial begin
        logic [0:W-1] seq_d;
        logic [0:W-1] prev_d;
        logic [2:0]   prev_m;
        logic         prev_e, prev_stall;
        beat_t        exp_b;
        int           sent, got, lat_a, lat_b, lat_c;
        logic         pat [4];

        tbl[0]  = '{8'h57, 3'd3, 8'hd9, 1'b0};
        tbl[1]  = '{8'h57, 3'd4, 8'h77, 1'b0};
        tbl[2]  = '{8'h57, 3'd5, 8'h9e, 1'b0};
        tbl[3]  = '{8'h57, 3'd6, 8'h67, 1'b0};
        tbl[4]  = '{8'h80, 3'd1, 8'h1b, 1'b0};
        tbl[5]  = '{8'h80, 3'd2, 8'h9b, 1'b0};
        tbl[6]  = '{8'h80, 3'd3, 8'hec, 1'b0};
        tbl[7]  = '{8'h57, 3'd1, 8'hae, 1'b0};
        tbl[8]  = '{8'h57, 3'd2, 8'hf9, 1'b0};
        tbl[9]  = '{8'h01, 3'd0, 8'h01, 1'b0};
        tbl[10] = '{8'h57, 3'd7, 8'h57, 1'b1};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        rdy_one = 1'b1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_mode = '0; in_data = '0;

        // Reset state
        #12;
        check("rst_out_valid", W'(ov_a), W'(1'b0));
        check("rst_done_cnt",  W'(dc_a), W'(16'd0));
        check("rst_out_data",  W'(od_a), W'(0));
        check("rst_out_mode",  W'(om_a), W'(3'd0));
        check("rst_out_err",   W'(oe_a), W'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", W'(ir_a), W'(1'b1));

        // Garbage on data/mode with in_valid low must not create beats
        in_data = 'x; in_mode = 'x;
        for (int j = 0; j < 4; j++) begin
            tick();
            @(negedge clk);
            check($sformatf("noval%0d_a", j), W'(ov_a), W'(1'b0));
            check($sformatf("noval%0d_c", j), W'(ov_c), W'(1'b0));
        end

        // Table vectors back-to-back: latency and full-rate order for STAGES 2/1/4
        do_reset();
        for (int j = 0; j < 11 + 5; j++) begin
            if (j < 11) begin
                in_valid = 1'b1; in_data = fill(tbl[j].b); in_mode = tbl[j].m;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk_out($sformatf("tbl_c%0d_a", j), j - 2, 11, tbl[(j >= 2 && j < 13) ? j - 2 : 0], ov_a, od_a, om_a, oe_a);
            chk_out($sformatf("tbl_c%0d_b", j), j - 1, 11, tbl[(j >= 1 && j < 12) ? j - 1 : 0], ov_b, od_b, om_b, oe_b);
            chk_out($sformatf("tbl_c%0d_c", j), j - 4, 11, tbl[(j >= 4 && j < 15) ? j - 4 : 0], ov_c, od_c, om_c, oe_c);
            tick();
        end
        check("tbl_done_a", W'(dc_a), W'(16'd11));
        check("tbl_done_b", W'(dc_b), W'(4'd11));

        // Byte k = k, mode 0 then mode 7
        do_reset();
        for (int k = 0; k < NB; k++) seq_d[8*k +: 8] = 8'(k);
        for (int j = 0; j < 4; j++) begin
            in_valid = (j < 2); in_data = seq_d; in_mode = (j == 0) ? 3'd0 : 3'd7;
            @(negedge clk);
            if (j >= 2) begin
                check($sformatf("ramp%0d_valid", j), W'(ov_a), W'(1'b1));
                check($sformatf("ramp%0d_data", j),  W'(od_a), W'(seq_d));
                check($sformatf("ramp%0d_mode", j),  W'(om_a), W'((j == 2) ? 3'd0 : 3'd7));
                check($sformatf("ramp%0d_err", j),   W'(oe_a), W'(j == 3));
            end
            tick();
        end
        in_valid = 1'b0;

        // Stalls with out_ready pattern 1,0,0,1: order, stability, in_ready relation
        do_reset();
        sent = 0; got = 0; prev_stall = 1'b0; prev_d = '0; prev_m = '0; prev_e = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            in_valid  = (sent < 8);
            in_data   = fill(8'h31 + 8'(sent) * 8'h25);
            in_mode   = 3'(sent);
            out_ready = pat[cyc % 4];
            @(negedge clk);
            check($sformatf("stall%0d_in_ready", cyc), W'(ir_a), W'(!(ov_a && !out_ready)));
            if (prev_stall) begin
                check($sformatf("stall%0d_hold_v", cyc), W'(ov_a), W'(1'b1));
                check($sformatf("stall%0d_hold_d", cyc), W'(od_a), W'(prev_d));
                check($sformatf("stall%0d_hold_m", cyc), W'(om_a), W'(prev_m));
                check($sformatf("stall%0d_hold_e", cyc), W'(oe_a), W'(prev_e));
            end
            if (in_valid && ir_a) begin
                q.push_back('{model(in_data, in_mode), in_mode, in_mode == 3'd7});
                sent++;
            end
            if (ov_a && out_ready) begin
                if (q.size() == 0) begin
                    check("stall_extra_beat", W'(1'b1), W'(1'b0));
                end else begin
                    exp_b = q.pop_front();
                    check($sformatf("stall_beat%0d_d", got), W'(od_a), W'(exp_b.d));
                    check($sformatf("stall_beat%0d_m", got), W'(om_a), W'(exp_b.m));
                    check($sformatf("stall_beat%0d_e", got), W'(oe_a), W'(exp_b.e));
                end
                got++;
            end
            prev_stall = ov_a && !out_ready;
            prev_d = od_a; prev_m = om_a; prev_e = oe_a;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stall_beats_out", W'(got), W'(8));
        @(negedge clk);
        check("stall_done_cnt", W'(dc_a), W'(16'd8));
        check("stall_drained", W'(ov_a), W'(1'b0));

        // Reset with two beats in flight, then latency of the next beat
        tick();
        in_valid = 1'b1; in_data = fill(8'h11); in_mode = 3'd1;
        tick();
        in_data = fill(8'h22);
        tick();
        in_valid = 1'b0;
        check("prerst_valid", W'(ov_a), W'(1'b1));
        #2 rst = 1'b1;
        #1;
        check("midrst_valid_a", W'(ov_a), W'(1'b0));
        check("midrst_valid_c", W'(ov_c), W'(1'b0));
        check("midrst_done",    W'(dc_a), W'(16'd0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        in_valid = 1'b1; in_data = fill(8'h57); in_mode = 3'd6;
        lat_a = -1; lat_b = -1; lat_c = -1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            if (ov_a && lat_a < 0) begin
                lat_a = j;
                check("postrst_data", W'(od_a), W'(fill(8'h67)));
            end
            if (ov_b && lat_b < 0) lat_b = j;
            if (ov_c && lat_c < 0) lat_c = j;
        end
        check("latency_s2", W'(lat_a), W'(2));
        check("latency_s1", W'(lat_b), W'(1));
        check("latency_s4", W'(lat_c), W'(4));

        // 17 completions: the 4-bit counters wrap to 1
        do_reset();
        for (int j = 0; j < 17 + 6; j++) begin
            in_valid = (j < 17); in_data = fill(8'(j)); in_mode = 3'(j % 7);
            tick();
        end
        @(negedge clk);
        check("wrap_done_a", W'(dc_a), W'(16'd17));
        check("wrap_done_b", W'(dc_b), W'(4'd1));
        check("wrap_done_c", W'(dc_c), W'(4'd1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
